icache_miss_unit: RTL
=====================

ICACHE_MISS_UNIT -- requirements
Module: icache_miss_unit

Interface
REQ-001 Parameter REQ_DEPTH, default 4, miss request queue depth (power of 2, >=2).
REQ-002 Parameter LINE_W, default 512, cache line width in bits.
REQ-003 Parameter MEM_DW, default 64, memory response beat width; BEATS = LINE_W/MEM_DW (8).
REQ-004 Clock clk, input, 1; reset rst_n, input, 1, asynchronous, active-low.
REQ-005 miss_valid_i input 1, miss_ready_o output 1, miss_addr_i input 64: miss requests from the icache.
REQ-006 mem_req_valid_o output 1, mem_req_ready_i input 1, mem_req_addr_o output 64: line read to memory.
REQ-007 mem_resp_valid_i input 1, mem_resp_data_i input MEM_DW, mem_resp_last_i input 1: read beats, no backpressure.
REQ-008 refill_valid_o output 1, refill_ready_i input 1, refill_data_o output LINE_W: line refill to the icache.
REQ-009 protocol_err_o output 1: sticky memory-protocol error flag.

Function
REQ-010 Miss accepted on miss_valid_i && miss_ready_o; address stored line-aligned (bits [5:0] zeroed).
REQ-011 miss_ready_o = !queue_full; push and pop in the same cycle allowed; when full, ready low regardless of pop.
REQ-012 FSM states IDLE, REQ, RECV, RESP; one memory transaction outstanding at a time; requests served strictly in FIFO order.
REQ-013 IDLE -> REQ when queue non-empty; a miss accepted in cycle N drives mem_req_valid_o no earlier than N+1.
REQ-014 REQ: mem_req_valid_o=1, mem_req_addr_o = queue head; held stable until mem_req_ready_i; handshake -> RECV, beat_cnt=0.
REQ-015 RECV: each mem_resp_valid_i writes beat into line buffer slice [beat_cnt*MEM_DW +: MEM_DW] (beat 0 = bits 63:0), beat_cnt increments.
REQ-016 RECV -> RESP on the BEATS-th beat; line completes on beat count only.
REQ-017 mem_resp_last_i on a beat other than BEATS-th, or absent on BEATS-th, sets protocol_err_o (cleared only by reset).
REQ-018 mem_resp_valid_i outside RECV ignored and sets protocol_err_o.
REQ-019 RESP: refill_valid_o=1, refill_data_o = line buffer, held until refill_ready_i; handshake pops queue head.
REQ-020 RESP handshake -> REQ if queue still non-empty after pop (including a same-cycle push), else IDLE.
REQ-021 refill_data_o is zero whenever refill_valid_o is low.
REQ-022 Minimum miss-to-refill latency with ready memory: accept N, mem_req N+1, beats N+2..N+9, refill_valid_o N+10.

Reset
REQ-023 Reset: state IDLE, queue empty, beat_cnt 0, line buffer 0; all outputs 0 except miss_ready_o=1 one cycle after reset deassertion (0 during reset).
REQ-024 Reset mid-transaction discards queue and partial line; subsequent stray beats obey REQ-018.

Configuration
REQ-025 Macro ICACHE_MISS_PERF_EN defined: adds outputs perf_miss_cnt_o[31:0] (+1 per accepted miss) and perf_busy_cyc_o[31:0] (+1 per cycle state!=IDLE), both saturating at 0xFFFFFFFF, reset 0.
REQ-026 Macro undefined: perf ports and counters absent; all other behaviour identical.

Structure
REQ-027 Shared package icache_pkg holds LINE_W, MEM_DW, BEATS, offset width, and the FSM state enum.
REQ-028 Request queue implemented as sub-module icache_miss_fifo (synchronous FIFO, full/empty, push/pop same cycle).

Verification
REQ-029 Single miss 0x8000_1234, mem ready, beats 0x0..0x7 with last on 8th -> mem_req_addr_o=0x8000_1200, refill_data_o beat k = k, refill at accept+10.
REQ-030 Five back-to-back misses, mem_req_ready_i held 0 -> miss_ready_o low after 4th accept; 5th accepted only after first refill pops.
REQ-031 Misses A=0x1000,B=0x2040 queued, refill_ready_i low 20 cycles on A -> refill_valid_o/data held stable, B request issued only after A handshake.
REQ-032 mem_resp_last_i on beat 3 -> protocol_err_o=1 from next cycle, line still completes after beat 8.
REQ-033 Reset asserted during RECV after 4 beats, then 4 stray beats -> no refill_valid_o, protocol_err_o=1, queue empty.
REQ-034 With ICACHE_MISS_PERF_EN, 3 misses served -> perf_miss_cnt_o=3, perf_busy_cyc_o equals total non-IDLE cycles counted by bench.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the icache miss unit: line geometry and FSM state encoding.
package icache_pkg;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned LINE_W   = 512;
  localparam int unsigned MEM_DW   = 64;
  localparam int unsigned BEATS    = LINE_W / MEM_DW;
  localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_RESP
  } miss_state_e;

endpackage

// File: rtl/icache_miss_fifo.sv
// Synchronous miss request FIFO. Exposes next-cycle head/empty/full so the
// owner can load registered outputs on the same edge as a push or pop.
module icache_miss_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_nxt_c,
  output logic         empty_nxt_c,
  output logic         full_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Next occupancy and the entry that will sit at the head after this edge.
  always_comb begin
    rd_ptr_inc  = PTR_W'(rd_ptr + 1'b1);
    count_nxt   = count + CNT_W'(push_i) - CNT_W'(pop_i);
    empty_nxt_c = (count_nxt == '0);
    full_nxt_c  = (count_nxt == CNT_W'(DEPTH));
    if ((count == '0) || (pop_i && (count == CNT_W'(1)))) begin
      head_nxt_c = push_data_i;
    end else if (pop_i) begin
      head_nxt_c = mem[rd_ptr_inc];
    end else begin
      head_nxt_c = mem[rd_ptr];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop_i)  rd_ptr <= rd_ptr_inc;
      count <= count_nxt;
    end
  end

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/icache_miss_unit.sv
// Icache miss unit: queues line misses, fetches each line from memory one
// transaction at a time in FIFO order, and returns the assembled line.
// Optional performance counters are built when ICACHE_MISS_PERF_EN is defined.
module icache_miss_unit #(
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned LINE_W    = icache_pkg::LINE_W,
  parameter int unsigned MEM_DW    = icache_pkg::MEM_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  logic [63:0]       miss_addr_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [63:0]       mem_req_addr_o,
  input  logic              mem_resp_valid_i,
  input  logic [MEM_DW-1:0] mem_resp_data_i,
  input  logic              mem_resp_last_i,
  output logic              refill_valid_o,
  input  logic              refill_ready_i,
  output logic [LINE_W-1:0] refill_data_o,
  output logic              protocol_err_o
`ifdef ICACHE_MISS_PERF_EN
  ,
  output logic [31:0]       perf_miss_cnt_o,
  output logic [31:0]       perf_busy_cyc_o
`endif
);

  import icache_pkg::*;

  localparam int unsigned NBEATS = LINE_W / MEM_DW;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

  miss_state_e       state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] line_nxt;
  logic [ADDR_W-1:0] miss_addr_aligned;
  logic [ADDR_W-1:0] head_nxt;
  logic              empty_nxt;
  logic              full_nxt;
  logic              push;
  logic              pop;
  logic              final_beat;

  assign miss_addr_aligned = miss_addr_i & ~OFF_MASK;
  assign push              = miss_valid_i && miss_ready_o;
  assign pop               = (state == ST_RESP) && refill_ready_i;
  assign final_beat        = (beat_cnt == CNT_W'(NBEATS - 1));

  icache_miss_fifo #(
    .DEPTH (REQ_DEPTH),
    .W     (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (miss_addr_aligned),
    .pop_i       (pop),
    .head_nxt_c  (head_nxt),
    .empty_nxt_c (empty_nxt),
    .full_nxt_c  (full_nxt)
  );

  // Line buffer with the current beat merged into its slice.
  always_comb begin
    line_nxt = line_buf;
    for (int unsigned k = 0; k < NBEATS; k++) begin
      if (beat_cnt == CNT_W'(k)) line_nxt[k*MEM_DW +: MEM_DW] = mem_resp_data_i;
    end
  end

  // Miss FSM with registered handshake outputs and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      beat_cnt        <= '0;
      line_buf        <= '0;
      miss_ready_o    <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      refill_valid_o  <= 1'b0;
      refill_data_o   <= '0;
      protocol_err_o  <= 1'b0;
    end else begin
      miss_ready_o <= !full_nxt;
      if (mem_resp_valid_i && (state != ST_RECV)) protocol_err_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!empty_nxt) begin
            state           <= ST_REQ;
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= head_nxt;
          end
        end
        ST_REQ: begin
          if (mem_req_ready_i) begin
            state           <= ST_RECV;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            beat_cnt        <= '0;
          end
        end
        ST_RECV: begin
          if (mem_resp_valid_i) begin
            line_buf <= line_nxt;
            beat_cnt <= CNT_W'(beat_cnt + 1'b1);
            if (mem_resp_last_i != final_beat) protocol_err_o <= 1'b1;
            if (final_beat) begin
              state          <= ST_RESP;
              refill_valid_o <= 1'b1;
              refill_data_o  <= line_nxt;
            end
          end
        end
        ST_RESP: begin
          if (refill_ready_i) begin
            refill_valid_o <= 1'b0;
            refill_data_o  <= '0;
            if (!empty_nxt) begin
              state           <= ST_REQ;
              mem_req_valid_o <= 1'b1;
              mem_req_addr_o  <= head_nxt;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ICACHE_MISS_PERF_EN
  // Saturating counters for accepted misses and non-idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_miss_cnt_o <= '0;
      perf_busy_cyc_o <= '0;
    end else begin
      if (push && (perf_miss_cnt_o != '1)) perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
      if ((state != ST_IDLE) && (perf_busy_cyc_o != '1)) perf_busy_cyc_o <= perf_busy_cyc_o + 32'd1;
    end
  end
`endif

endmodule
